// File: rtl/alu_multicycle_if.sv
// Operand/command request and result/flags response channels of alu_multicycle.
// Both channels use valid/ready handshakes; the ALU side uses the slave modport.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic [2:0]       command;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, operandA, operandB, command, out_ready,
        input  in_ready, out_valid, result, carryout, overflow, zero
    );

    modport slave (
        input  in_valid, operandA, operandB, command, out_ready,
        output in_ready, out_valid, result, carryout, overflow, zero
    );
endinterface

// File: rtl/alu_multicycle.sv
// Bit-serial-by-slice ALU: one SLICE-bit adder/logic unit reused for WIDTH/SLICE cycles.
// out_valid rises NSLICES cycles after accept; result and flags are held in DONE until out_ready.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic               clk,
    input  logic               reset,
    alu_multicycle_if.slave    bus
);
    localparam int NSLICES = WIDTH / SLICE;
    localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam int SW      = SLICE + 1;
    localparam logic [CW-1:0]    LAST_SLICE = CW'(NSLICES - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    generate
        if ((SLICE < 1) || (SLICE > WIDTH) || (WIDTH < 2) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
            $error("alu_multicycle: WIDTH must be >= 2 and a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryout_q, carryout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             arith, invert_b;
    int               idx;
    logic [SLICE-1:0] a_sl, b_sl, sl_res;
    logic [SLICE:0]   sum;
    logic             c_out, c_msb_in, ovf, slt;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carryout_d  = carryout_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        arith    = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
        invert_b = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
        idx      = int'(cnt_q) * SLICE;
        a_sl     = SLICE'(a_q >> idx);
        b_sl     = SLICE'(b_q >> idx) ^ {SLICE{invert_b}};
        sum      = {1'b0, a_sl} + {1'b0, b_sl} + SW'(carry_q);

        case (cmd_q)
            CMD_XOR:  sl_res = a_sl ^ b_sl;
            CMD_AND:  sl_res = a_sl & b_sl;
            CMD_NAND: sl_res = ~(a_sl & b_sl);
            CMD_NOR:  sl_res = ~(a_sl | b_sl);
            CMD_OR:   sl_res = a_sl | b_sl;
            default:  sl_res = sum[SLICE-1:0];
        endcase

        // Carry into the top bit of this slice is recovered from its sum bit.
        c_out    = sum[SLICE];
        c_msb_in = sum[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];
        ovf      = c_out ^ c_msb_in;
        slt      = sum[SLICE-1] ^ ovf;
        res_next = (result_q & ~(SLICE_MASK << idx)) | (WIDTH'(sl_res) << idx);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.operandA;
                    b_d        = bus.operandB;
                    cmd_d      = bus.command;
                    cnt_d      = '0;
                    carry_d    = (bus.command == CMD_SUB) || (bus.command == CMD_SLT);
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                result_d = res_next;
                carry_d  = arith ? c_out : 1'b0;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_SLICE) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    carryout_d  = 1'b0;
                    overflow_d  = 1'b0;
                    if ((cmd_q == CMD_ADD) || (cmd_q == CMD_SUB)) begin
                        carryout_d = c_out;
                        overflow_d = ovf;
                    end
                    if (cmd_q == CMD_SLT) begin
                        result_d = WIDTH'(slt);
                    end
                    zero_d = (result_d == '0);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cmd_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carryout_q  <= carryout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carryout  = carryout_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Drives a 32/4 and an 8/8 instance of alu_multicycle and compares every result
// against an arithmetic reference model of the command set.
module tb_alu_multicycle;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(32)) bus32 ();
    alu_multicycle_if #(.WIDTH(8))  bus8 ();

    alu_multicycle #(.WIDTH(32), .SLICE(4)) dut32 (.clk(clk), .reset(rst), .bus(bus32));
    alu_multicycle #(.WIDTH(8),  .SLICE(8)) dut8  (.clk(clk), .reset(rst), .bus(bus8));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic on w-bit values held in 64-bit containers.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic [2:0] cmd, output logic [63:0] res,
                                  output logic c, output logic v, output logic z);
        logic [63:0] mask;
        logic [64:0] full;
        logic        sa, sb;
        mask = (64'd1 << w) - 64'd1;
        a    = a & mask;
        b    = b & mask;
        sa   = a[w-1];
        sb   = b[w-1];
        c    = 1'b0;
        v    = 1'b0;
        case (cmd)
            3'd0: begin
                full = {1'b0, a} + {1'b0, b};
                res  = full[63:0] & mask;
                c    = full[w];
                v    = (sa == sb) && (res[w-1] != sa);
            end
            3'd1: begin
                full = {1'b0, a} + {1'b0, (~b & mask)} + 65'd1;
                res  = full[63:0] & mask;
                c    = full[w];
                v    = (sa != sb) && (res[w-1] != sa);
            end
            3'd2: res = a ^ b;
            3'd3: res = (sa != sb) ? {63'd0, sa} : {63'd0, (a < b)};
            3'd4: res = a & b;
            3'd5: res = ~(a & b) & mask;
            3'd6: res = ~(a | b) & mask;
            default: res = a | b;
        endcase
        z = (res == 64'd0);
    endfunction

    task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd,
                           input int hold, input bit toggle, output logic [35:0] obs);
        logic [63:0] er;
        logic        ec, ev, ez;
        int          lat;
        model(32, {32'd0, a}, {32'd0, b}, cmd, er, ec, ev, ez);
        check("in_ready_idle32", bus32.in_ready, 1);
        bus32.in_valid = 1'b1;
        bus32.operandA = a;
        bus32.operandB = b;
        bus32.command  = cmd;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        lat = 0;
        while (bus32.out_valid !== 1'b1 && lat < 40) begin
            if (toggle) begin
                bus32.in_valid = 1'($urandom_range(0, 1));
                bus32.operandA = $urandom;
                bus32.operandB = $urandom;
                bus32.command  = 3'($urandom_range(0, 7));
            end
            @(posedge clk); #1;
            lat++;
        end
        bus32.in_valid = 1'b0;
        check("latency32", lat, 8);
        check("result32", bus32.result, er[31:0]);
        check("carry32", bus32.carryout, ec);
        check("ovf32", bus32.overflow, ev);
        check("zero32", bus32.zero, ez);
        obs = {bus32.result, bus32.carryout, bus32.overflow, bus32.zero, bus32.out_valid};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold32", {bus32.out_valid, bus32.in_ready, bus32.result, bus32.carryout,
                             bus32.overflow, bus32.zero}, {1'b1, 1'b0, er[31:0], ec, ev, ez});
        end
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        check("out_valid_drop32", bus32.out_valid, 0);
        check("in_ready_back32", bus32.in_ready, 1);
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] cmd,
                          output logic [11:0] obs);
        logic [63:0] er;
        logic        ec, ev, ez;
        int          lat;
        model(8, {56'd0, a}, {56'd0, b}, cmd, er, ec, ev, ez);
        bus8.in_valid = 1'b1;
        bus8.operandA = a;
        bus8.operandB = b;
        bus8.command  = cmd;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (bus8.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency8", lat, 1);
        check("flags8", {bus8.result, bus8.carryout, bus8.overflow, bus8.zero},
                        {er[7:0], ec, ev, ez});
        obs = {bus8.result, bus8.carryout, bus8.overflow, bus8.zero, bus8.out_valid};
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        check("handshake8", {bus8.out_valid, bus8.in_ready}, 2'b01);
    endtask

    initial begin
        logic [35:0] o32;
        logic [11:0] o8;
        logic [31:0] ra, rb;
        int          seen;

        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
        bus32.operandA = '0;   bus32.operandB  = '0; bus32.command = '0;
        bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0;
        bus8.operandA  = '0;   bus8.operandB   = '0; bus8.command  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset32", {bus32.in_ready, bus32.out_valid, bus32.result, bus32.carryout,
                          bus32.overflow, bus32.zero}, {1'b1, 1'b0, 32'd0, 3'd0});
        check("reset8", {bus8.in_ready, bus8.out_valid, bus8.result, bus8.zero}, {2'b10, 9'd0});
        rst = 1'b0;
        @(posedge clk); #1;

        // Test-plan operations with the literal expected values
        do_op32(32'h7FFFFFFF, 32'h00000001, 3'd0, 0, 1'b0, o32);
        check("add_ovf_lit", o32, {32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1});
        do_op32(32'h00000005, 32'h00000005, 3'd1, 5, 1'b0, o32);
        check("sub_zero_lit", o32, {32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1});
        do_op32(32'hFFFFFFFF, 32'h00000001, 3'd3, 0, 1'b0, o32);
        check("slt_neg_lit", o32, {32'h00000001, 3'b000, 1'b1});
        do_op32(32'h7FFFFFFF, 32'h80000000, 3'd3, 0, 1'b0, o32);
        check("slt_ovf_lit", o32, {32'h00000000, 3'b001, 1'b1});
        do_op32(32'hF0F0F0F0, 32'hFF00FF00, 3'd4, 0, 1'b0, o32);
        check("and_lit", o32, {32'hF000F000, 3'b000, 1'b1});
        do_op32(32'hF0F0F0F0, 32'hFF00FF00, 3'd5, 0, 1'b0, o32);
        check("nand_lit", o32, {32'h0FFF0FFF, 3'b000, 1'b1});
        do_op32(32'hF0F0F0F0, 32'hFF00FF00, 3'd6, 0, 1'b0, o32);
        check("nor_lit", o32, {32'h000F000F, 3'b000, 1'b1});
        do_op32(32'hF0F0F0F0, 32'hFF00FF00, 3'd7, 0, 1'b0, o32);
        check("or_lit", o32, {32'hFFF0FFF0, 3'b000, 1'b1});
        do_op32(32'hF0F0F0F0, 32'hFF00FF00, 3'd2, 2, 1'b1, o32);
        check("xor_toggle_lit", o32, {32'h0FF00FF0, 3'b000, 1'b1});

        do_op8(8'hFF, 8'h01, 3'd0, o8);
        check("add8_wrap_lit", o8, {8'h00, 1'b1, 1'b0, 1'b1, 1'b1});

        // Randomized operations; equal operands are forced now and then to reach zero/SLT edges
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
            if ($urandom_range(0, 3) == 0) rb = {~ra[31], rb[30:0]};
            do_op32(ra, rb, 3'($urandom_range(0, 7)), $urandom_range(0, 2), (i % 3) == 0, o32);
        end
        for (int i = 0; i < 20; i++) begin
            do_op8(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), o8);
        end

        // Abort an operation part-way through RUN
        bus32.in_valid = 1'b1;
        bus32.operandA = 32'h12345678;
        bus32.operandB = 32'h11111111;
        bus32.command  = 3'd0;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_outputs", {bus32.in_ready, bus32.out_valid, bus32.result, bus32.carryout,
                                bus32.overflow, bus32.zero}, {1'b1, 1'b0, 32'd0, 3'd0});
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_in_ready", bus32.in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus32.out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        check("abort_no_valid", seen, 0);

        do_op32(32'h00000003, 32'h00000007, 3'd1, 1, 1'b0, o32);
        check("post_abort_sub_lit", o32, {32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
